mandel_scheduler: RTL
=====================

MANDEL_SCHEDULER -- requirements
Module: mandel_scheduler

Interface
REQ-001 SHALL have parameter NUM_ENGINES, default 4, number of iteration engines scheduled.
REQ-002 SHALL have parameter X_SIZE, default 640, pixels per line.
REQ-003 SHALL have parameter Y_SIZE, default 480, lines per frame.
REQ-004 SHALL have parameter ITER_W, default 8, iteration-count width.
REQ-005 SHALL have port out_stream_aclk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port periph_resetn  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port enable  in  1  level; start/continue frames.
REQ-008 SHALL have port eng_start  out  NUM_ENGINES  one-hot single-cycle job pulse.
REQ-009 SHALL have port eng_x  out  10  pixel x of job, valid with eng_start.
REQ-010 SHALL have port eng_y  out  9  pixel y of job, valid with eng_start.
REQ-011 SHALL have port eng_done  in  NUM_ENGINES  level; result held until acked.
REQ-012 SHALL have port eng_iter  in  NUM_ENGINES*ITER_W  packed results, engine i at [i*ITER_W +: ITER_W].
REQ-013 SHALL have port eng_ack  out  NUM_ENGINES  one-hot single-cycle result acknowledge.
REQ-014 SHALL have port out_tdata  out  ITER_W  AXI-Stream iteration count.
REQ-015 SHALL have ports out_tvalid out 1, out_tready in 1, out_tlast out 1 (EOL), out_tuser out 1 (SOF).
REQ-016 SHALL have port frame_done  out  1  single-cycle pulse after last pixel accepted.
REQ-017 SHALL have port frame_cycles  out  32  cycles of last completed frame.

Function
REQ-018 SHALL implement FSM IDLE->RUN (enable high) ; RUN->DRAIN (pixel X_SIZE-1,Y_SIZE-1 issued) ; DRAIN->RUN if enable high else IDLE, on last pixel accepted.
REQ-019 SHALL issue jobs in raster order to engines strictly round-robin (job k -> engine k mod NUM_ENGINES), at most one per cycle, only in RUN.
REQ-020 SHALL issue to engine issue_ptr only when its outstanding bit is clear; ack clearing the bit in the same cycle does not permit issue until next cycle.
REQ-021 SHALL retire results strictly round-robin from retire_ptr so output order equals raster order.
REQ-022 SHALL pulse eng_ack[retire_ptr] and load output register in the cycle eng_done[retire_ptr] is high and output register is empty or being consumed (tvalid&&tready); out_tvalid rises next cycle.
REQ-023 SHALL hold out_tdata/tlast/tuser stable while out_tvalid && !out_tready.
REQ-024 SHALL assert out_tlast on retired pixel x==X_SIZE-1 and out_tuser on x==0,y==0 only.
REQ-025 SHALL sustain one pixel/cycle output when engines keep up and out_tready stays high.
REQ-026 SHALL let enable fall mid-frame complete the current frame, then enter IDLE.
REQ-027 SHALL pulse frame_done on the cycle after the last pixel handshake; back-to-back frames start issuing that same cycle.

Reset
REQ-028 SHALL on periph_resetn low set FSM IDLE, pointers/counters 0, outstanding bits 0, eng_start/eng_ack/out_tvalid/out_tlast/out_tuser/frame_done 0, out_tdata 0, frame_cycles 0.
REQ-029 SHALL on reset mid-frame discard all in-flight jobs; engines share the same reset.

Configuration
REQ-030 SHALL with MANDEL_SCHED_STATS_EN defined count cycles from RUN entry to frame_done and latch into frame_cycles at frame_done.
REQ-031 SHALL without MANDEL_SCHED_STATS_EN keep port frame_cycles, driven constant 0, no counter logic.

Structure
REQ-032 SHALL place state enum, X_W=10, Y_W=9 constants in package mandel_sched_pkg.
REQ-033 SHALL implement output register as sub-module mandel_sched_outreg.

Verification (NUM_ENGINES=2, X_SIZE=4, Y_SIZE=2, ITER_W=8)
REQ-034 SHALL verify: engines return iter=x+4y after 3 cycles, tready=1 -> 8 beats data 0..7, tuser on beat 0, tlast on beats 3,7, one frame_done.
REQ-035 SHALL verify: engine1 latency 10, engine0 latency 1 -> output still 0..7 in order, no dropped/duplicated eng_ack.
REQ-036 SHALL verify: tready low 5 cycles at beat 2 -> data 2 held stable, no new eng_ack to that engine while output full.
REQ-037 SHALL verify: enable dropped after 3rd beat -> frame completes 8 beats, FSM IDLE, no further eng_start.
REQ-038 SHALL verify: reset asserted at beat 5 -> next cycle all outputs 0; re-enable gives fresh frame starting tuser with data 0.
REQ-039 SHALL verify: MANDEL_SCHED_STATS_EN defined, engine latency 3, tready=1 -> frame_cycles nonzero and equal to measured RUN-to-frame_done count; undefined -> 0.

Source files
------------

// File: rtl/mandel_sched_pkg.sv
// rtl/mandel_sched_pkg.sv - shared state encoding and pixel coordinate widths for the Mandelbrot scheduler.
package mandel_sched_pkg;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

endpackage

// File: rtl/mandel_sched_outreg.sv
// rtl/mandel_sched_outreg.sv - single-entry stream output register; payload held while valid and not ready.
module mandel_sched_outreg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         resetn_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         tready_i,
  output logic         tvalid_o,
  output logic [W-1:0] data_o,
  output logic         can_load_o,
  output logic         accept_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign accept_o   = valid_q && tready_i;
  assign can_load_o = !valid_q || tready_i;
  assign tvalid_o   = valid_q;
  assign data_o     = data_q;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (accept_o) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mandel_scheduler.sv
// rtl/mandel_scheduler.sv - raster-order job issue and in-order retirement across iteration engines.
// Optional frame cycle statistics are built when MANDEL_SCHED_STATS_EN is defined.
module mandel_scheduler
  import mandel_sched_pkg::*;
#(
  parameter int NUM_ENGINES = 4,
  parameter int X_SIZE      = 640,
  parameter int Y_SIZE      = 480,
  parameter int ITER_W      = 8
) (
  input  logic                          out_stream_aclk,
  input  logic                          periph_resetn,
  input  logic                          enable,
  output logic [NUM_ENGINES-1:0]        eng_start,
  output logic [X_W-1:0]                eng_x,
  output logic [Y_W-1:0]                eng_y,
  input  logic [NUM_ENGINES-1:0]        eng_done,
  input  logic [NUM_ENGINES*ITER_W-1:0] eng_iter,
  output logic [NUM_ENGINES-1:0]        eng_ack,
  output logic [ITER_W-1:0]             out_tdata,
  output logic                          out_tvalid,
  input  logic                          out_tready,
  output logic                          out_tlast,
  output logic                          out_tuser,
  output logic                          frame_done,
  output logic [31:0]                   frame_cycles
);

  localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam int OW    = ITER_W + 3;

  sched_state_e           state_q, state_d;
  logic [X_W-1:0]         issue_x_q, issue_x_d, retire_x_q, retire_x_d;
  logic [Y_W-1:0]         issue_y_q, issue_y_d, retire_y_q, retire_y_d;
  logic [PTR_W-1:0]       issue_ptr_q, issue_ptr_d, retire_ptr_q, retire_ptr_d;
  logic [NUM_ENGINES-1:0] outstanding_q, outstanding_d;
  logic [NUM_ENGINES-1:0] eng_start_q;
  logic [X_W-1:0]         eng_x_q;
  logic [Y_W-1:0]         eng_y_q;
  logic                   frame_done_q;

  logic          issue_fire, issue_last_x, issue_last;
  logic          retire_fire, retire_last_x, retire_last;
  logic          out_can_load, out_accept, last_accept;
  logic [OW-1:0] out_din, out_dout;

  assign issue_fire   = (state_q == ST_RUN) && !outstanding_q[issue_ptr_q];
  assign issue_last_x = issue_x_q == X_W'(X_SIZE - 1);
  assign issue_last   = issue_last_x && (issue_y_q == Y_W'(Y_SIZE - 1));

  // Only the engine at retire_ptr may retire, which keeps output in raster order.
  assign retire_fire   = outstanding_q[retire_ptr_q] && eng_done[retire_ptr_q] && out_can_load;
  assign retire_last_x = retire_x_q == X_W'(X_SIZE - 1);
  assign retire_last   = retire_last_x && (retire_y_q == Y_W'(Y_SIZE - 1));

  // Payload packs {end_of_frame, sof, eol, iteration}.
  assign out_din = {retire_last,
                    (retire_x_q == '0) && (retire_y_q == '0),
                    retire_last_x,
                    eng_iter[int'(retire_ptr_q)*ITER_W +: ITER_W]};

  assign last_accept = out_accept && out_dout[ITER_W+2];

  assign eng_ack    = retire_fire ? (NUM_ENGINES'(1) << retire_ptr_q) : '0;
  assign eng_start  = eng_start_q;
  assign eng_x      = eng_x_q;
  assign eng_y      = eng_y_q;
  assign frame_done = frame_done_q;
  assign out_tdata  = out_dout[ITER_W-1:0];
  assign out_tlast  = out_dout[ITER_W];
  assign out_tuser  = out_dout[ITER_W+1];

  always_comb begin
    issue_x_d     = issue_x_q;
    issue_y_d     = issue_y_q;
    issue_ptr_d   = issue_ptr_q;
    retire_x_d    = retire_x_q;
    retire_y_d    = retire_y_q;
    retire_ptr_d  = retire_ptr_q;
    outstanding_d = outstanding_q;
    state_d       = state_q;

    if (issue_fire) begin
      outstanding_d[issue_ptr_q] = 1'b1;
      issue_ptr_d = (issue_ptr_q == PTR_W'(NUM_ENGINES - 1)) ? '0 : issue_ptr_q + 1'b1;
      if (issue_last_x) begin
        issue_x_d = '0;
        issue_y_d = (issue_y_q == Y_W'(Y_SIZE - 1)) ? '0 : issue_y_q + 1'b1;
      end else begin
        issue_x_d = issue_x_q + 1'b1;
      end
    end

    if (retire_fire) begin
      outstanding_d[retire_ptr_q] = 1'b0;
      retire_ptr_d = (retire_ptr_q == PTR_W'(NUM_ENGINES - 1)) ? '0 : retire_ptr_q + 1'b1;
      if (retire_last_x) begin
        retire_x_d = '0;
        retire_y_d = (retire_y_q == Y_W'(Y_SIZE - 1)) ? '0 : retire_y_q + 1'b1;
      end else begin
        retire_x_d = retire_x_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (issue_fire && issue_last) state_d = ST_DRAIN;
      ST_DRAIN: if (last_accept) state_d = enable ? ST_RUN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge out_stream_aclk) begin
    if (!periph_resetn) begin
      state_q       <= ST_IDLE;
      issue_x_q     <= '0;
      issue_y_q     <= '0;
      issue_ptr_q   <= '0;
      retire_x_q    <= '0;
      retire_y_q    <= '0;
      retire_ptr_q  <= '0;
      outstanding_q <= '0;
      eng_start_q   <= '0;
      eng_x_q       <= '0;
      eng_y_q       <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      issue_x_q     <= issue_x_d;
      issue_y_q     <= issue_y_d;
      issue_ptr_q   <= issue_ptr_d;
      retire_x_q    <= retire_x_d;
      retire_y_q    <= retire_y_d;
      retire_ptr_q  <= retire_ptr_d;
      outstanding_q <= outstanding_d;
      eng_start_q   <= issue_fire ? (NUM_ENGINES'(1) << issue_ptr_q) : '0;
      if (issue_fire) begin
        eng_x_q <= issue_x_q;
        eng_y_q <= issue_y_q;
      end
      frame_done_q  <= last_accept;
    end
  end

  mandel_sched_outreg #(.W(OW)) u_outreg (
    .clk_i      (out_stream_aclk),
    .resetn_i   (periph_resetn),
    .load_i     (retire_fire),
    .data_i     (out_din),
    .tready_i   (out_tready),
    .tvalid_o   (out_tvalid),
    .data_o     (out_dout),
    .can_load_o (out_can_load),
    .accept_o   (out_accept)
  );

`ifdef MANDEL_SCHED_STATS_EN
  logic [31:0] cyc_q, frame_cycles_q;
  logic        run_entry;

  // Count restarts on every RUN entry, including the back-to-back DRAIN->RUN edge.
  assign run_entry = (state_q != ST_RUN) && (state_d == ST_RUN);

  always_ff @(posedge out_stream_aclk) begin
    if (!periph_resetn) begin
      cyc_q          <= '0;
      frame_cycles_q <= '0;
    end else begin
      if (run_entry) begin
        cyc_q <= '0;
      end else if (state_q != ST_IDLE) begin
        cyc_q <= cyc_q + 32'd1;
      end
      if (last_accept) frame_cycles_q <= cyc_q + 32'd1;
    end
  end

  assign frame_cycles = frame_cycles_q;
`else
  assign frame_cycles = '0;
`endif

endmodule
